// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1/8N2 UART transmitter with valid/ready byte input.
//            Optional even parity bit when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  output logic       axior,
  output logic       axiod,
  output logic       tx_done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                axiod_q, axiod_d;
  logic                axior_q, axior_d;
  logic                baud_last;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);
  assign axiod     = axiod_q;
  assign axior     = axior_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (axiid_accept(axiiv, axior_q)) begin
          shift_d = axiid;
`ifdef UART_TX_PARITY_EN
          parity_d = ^axiid;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) state_d = S_DATA;
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // bit_q counts stop bits here; the frame ends on the last one's final clock
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            tx_done = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line is driven from the current state, so it lags the state by one clock
    axiod_d = 1'b1;
    case (state_q)
      S_START:  axiod_d = 1'b0;
      S_DATA:   axiod_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: axiod_d = parity_q;
`endif
      default:  axiod_d = 1'b1;
    endcase

    axior_d = (state_d == S_IDLE);
  end

  function automatic logic axiid_accept(input logic valid, input logic ready);
    return valid && ready;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      axiod_q  <= 1'b1;
      axior_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      axiod_q  <= axiod_d;
      axior_q  <= axior_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx (CLKS_PER_BIT=4); line decoder
//            plus directed byte table and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================

module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int SB  = 2;
  localparam int PAR = 1;
`else
  localparam int SB  = 1;
  localparam int PAR = 0;
`endif
  localparam int NB    = 10 + PAR + (SB - 1);
  localparam int FRAME = NB * CPB;

  logic       clk;
  logic       rst;
  logic       axiiv;
  logic [7:0] axiid;
  logic       axior;
  logic       axiod;
  logic       tx_done;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk     (clk),
    .rst     (rst),
    .axiiv   (axiiv),
    .axiid   (axiid),
    .axior   (axior),
    .axiod   (axiod),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Line-side observer: timestamps per negedge, frames rebuilt from axiod
  int          cyc = 0;
  int          done_q[$];
  int          acc_q[$];
  int          start_q[$];
  logic [11:0] frame_q[$];
  int          werr = 0;
  int          rdy_err = 0;

  initial begin
    bit          busy;
    bit          prev_done;
    int          s;
    int          off;
    logic [11:0] raw;
    busy = 1'b0;
    prev_done = 1'b0;
    s = 0;
    raw = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_done && axior !== 1'b1) rdy_err++;
      prev_done = (tx_done === 1'b1);
      if (tx_done === 1'b1) done_q.push_back(cyc);
      if (rst === 1'b0 && axiiv === 1'b1 && axior === 1'b1) acc_q.push_back(cyc);
      if (rst !== 1'b0) begin
        busy = 1'b0;
      end else if (!busy && axiod === 1'b0) begin
        busy = 1'b1;
        s    = cyc;
        raw  = '0;
      end
      if (busy) begin
        off = cyc - s;
        if (off % CPB == 0) raw[off / CPB] = axiod;
        else if (axiod !== raw[off / CPB]) werr++;
        if (off == FRAME - 1) begin
          frame_q.push_back(raw);
          start_q.push_back(s);
          busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (axior !== 1'b1 && i < 300) begin
      tick();
      i++;
    end
    if (axior !== 1'b1) check("ready_timeout", {31'd0, axior}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    wait_ready();
    axiiv = 1'b1;
    axiid = d;
    tick();
    axiiv = 1'b0;
    check("axior_drop", {31'd0, axior}, 32'd0);
  endtask

  task automatic wait_frames(input int nd, input int nf);
    int i;
    i = 0;
    while ((done_q.size() < nd || frame_q.size() < nf) && i < 400) begin
      tick();
      i++;
    end
    check("frame_wait", {31'd0, (done_q.size() >= nd && frame_q.size() >= nf)}, 32'd1);
  endtask

  task automatic run_vec(input string name, input logic [7:0] d, input logic [11:0] exp_raw);
    int n0, f0, a0;
    n0 = done_q.size();
    f0 = frame_q.size();
    a0 = acc_q.size();
    send_byte(d);
    wait_frames(n0 + 1, f0 + 1);
    if (frame_q.size() > f0 && done_q.size() > n0 && acc_q.size() > a0) begin
      check({name, "_line"},  {20'd0, frame_q[f0]}, {20'd0, exp_raw});
      check({name, "_len"},   done_q[n0] - acc_q[a0], FRAME);
      check({name, "_start"}, start_q[f0] - acc_q[a0], 32'd2);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [11:0] raw;
  } vec_t;

  vec_t vecs[3];

  // Expected line images, bit 0 first on the wire
`ifdef UART_TX_PARITY_EN
  localparam logic [11:0] RAW_00 = 12'hC00;
  localparam logic [11:0] RAW_FF = 12'hDFE;
  localparam logic [11:0] RAW_81 = 12'hD02;
  localparam logic [11:0] RAW_12 = 12'hC24;
`else
  localparam logic [11:0] RAW_00 = 12'h200;
  localparam logic [11:0] RAW_FF = 12'h3FE;
  localparam logic [11:0] RAW_81 = 12'h302;
  localparam logic [11:0] RAW_12 = 12'h224;
`endif

  initial begin
    int n0, f0, a0, i;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{data: 8'hA5, raw: 12'hD4A};
    vecs[1] = '{data: 8'h01, raw: 12'hE02};
    vecs[2] = '{data: 8'h3C, raw: 12'hC78};
`else
    vecs[0] = '{data: 8'hA5, raw: 12'h34A};
    vecs[1] = '{data: 8'h01, raw: 12'h202};
    vecs[2] = '{data: 8'h3C, raw: 12'h278};
`endif

    rst   = 1'b1;
    axiiv = 1'b0;
    axiid = 8'h00;

    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_axiod",   {31'd0, axiod},   32'd1);
      check("rst_txdone",  {31'd0, tx_done}, 32'd0);
      check("rst_axior",   {31'd0, axior},   32'd0);
    end
    rst = 1'b0;
    tick();
    check("axior_after_rst", {31'd0, axior}, 32'd1);

    for (int k = 0; k < 3; k++) begin
      run_vec($sformatf("vec%0d", k), vecs[k].data, vecs[k].raw);
    end

    // Back-to-back: valid held high across two frames
    n0 = done_q.size();
    f0 = frame_q.size();
    a0 = acc_q.size();
    wait_ready();
    axiiv = 1'b1;
    axiid = 8'h00;
    tick();
    axiid = 8'hFF;
    i = 0;
    while (acc_q.size() < a0 + 2 && i < 200) begin
      tick();
      i++;
    end
    axiiv = 1'b0;
    wait_frames(n0 + 2, f0 + 2);
    if (frame_q.size() >= f0 + 2 && done_q.size() >= n0 + 1 && acc_q.size() >= a0 + 2) begin
      check("b2b_line0", {20'd0, frame_q[f0]},     {20'd0, RAW_00});
      check("b2b_line1", {20'd0, frame_q[f0 + 1]}, {20'd0, RAW_FF});
      check("b2b_accept_gap", acc_q[a0 + 1] - done_q[n0], 32'd1);
      check("b2b_start_gap", start_q[f0 + 1] - start_q[f0], FRAME + 1);
    end
    for (int k = 0; k < 10; k++) tick();
    check("b2b_done_count", done_q.size() - n0, 32'd2);

    // Valid pulsed mid-frame must be ignored
    n0 = done_q.size();
    f0 = frame_q.size();
    a0 = acc_q.size();
    send_byte(8'h81);
    for (int k = 0; k < 8; k++) tick();
    axiiv = 1'b1;
    axiid = 8'h3C;
    check("busy_axior", {31'd0, axior}, 32'd0);
    tick();
    axiiv = 1'b0;
    wait_frames(n0 + 1, f0 + 1);
    for (int k = 0; k < 60; k++) tick();
    if (frame_q.size() > f0) check("ignore_line", {20'd0, frame_q[f0]}, {20'd0, RAW_81});
    check("ignore_frames",  frame_q.size() - f0, 32'd1);
    check("ignore_accepts", acc_q.size() - a0,   32'd1);
    check("ignore_dones",   done_q.size() - n0,  32'd1);

    // Reset during data bit 3 of 0x55 aborts the frame
    n0 = done_q.size();
    f0 = frame_q.size();
    send_byte(8'h55);
    for (int k = 0; k < 18; k++) tick();
    rst = 1'b1;
    tick();
    check("abort_axiod",  {31'd0, axiod},   32'd1);
    check("abort_txdone", {31'd0, tx_done}, 32'd0);
    check("abort_axior",  {31'd0, axior},   32'd0);
    rst = 1'b0;
    tick();
    check("abort_axior_release", {31'd0, axior}, 32'd1);
    for (int k = 0; k < 60; k++) tick();
    check("abort_no_done",  done_q.size() - n0,  32'd0);
    check("abort_no_frame", frame_q.size() - f0, 32'd0);
    run_vec("after_abort", 8'h12, RAW_12);

    for (int k = 0; k < 5; k++) tick();
    check("bit_width",        werr,    32'd0);
    check("ready_after_done", rdy_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the PC-bound counterpart of the board's UART receiver.
- Accepts one byte per valid/ready handshake from FPGA logic and serializes it onto the FTDI tx pin, LSB first, at a fixed baud derived from the 100 MHz system clock.
- Sits beside the receiver in the PC<->FPGA link top level and drives the board `tx` output.

Parameters:
- CLKS_PER_BIT, 868: system clocks per UART bit (100 MHz / 115200). Legal values are 2 and above.
- STOP_BITS, 1: number of stop bits per frame. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- axiiv  input  1  byte valid from user logic
- axiid  input  8  byte to transmit
- axior  output  1  ready; high when a new byte can be accepted
- axiod  output  1  serial line to the PC (idle high)
- tx_done  output  1  one-cycle pulse when a frame's last stop bit completes

Clocking/reset: one clock, `clk`. Reset `rst` is synchronous and active-high.

Behaviour:
- Reset values (on the edge where rst=1):
  - axiod=1, axior=0, tx_done=0.
  - State=IDLE, bit counter=0, baud counter=0.
  - axior rises the first cycle after rst deasserts.
- Handshake:
  - A byte is accepted on a rising edge where axiiv && axior; axiid is latched into a shift register that edge.
  - axior is high only in IDLE; it drops the cycle after acceptance.
  - axiiv while axior=0 is ignored. The source must hold the byte until accepted. No buffering.
- States:
  - IDLE: axiod=1. On accept -> START.
  - START: axiod=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: axiod = shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit. After 8 bits -> STOP (or PARITY when the optional feature is enabled).
  - STOP: axiod=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE, with tx_done=1 for exactly that final transition cycle.
- Timing:
  - If accepted at edge N, axiod goes low at edge N+1.
  - Total frame = (1+8+STOP_BITS)*CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity).
  - tx_done asserts on the last cycle of the stop period; axior is high the following cycle.
  - Back-to-back bytes: idle gap between frames is exactly 1 cycle.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary; no drift across bits.
- Simultaneous events:
  - rst overrides everything, including axiiv && axior in the same cycle; that byte is not accepted.
  - A mid-frame rst returns axiod to 1 on that edge, discards the frame and produces no tx_done.
- axiod is registered (glitch-free); no combinational path from axiid/axiiv to axiod.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - It drives even parity: the XOR of the 8 latched data bits, computed from the byte at accept time.
  - Frame length grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; the frame is pure 8N1/8N2.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- Reset held 3 cycles, then released -> axiod=1, tx_done=0 throughout reset; axior=1 one cycle after release.
- Send 0xA5 -> axiod sequence per 4-cycle bit: 0, then 1,0,1,0,0,1,0,1, then 1. Frame is 40 cycles; tx_done pulses once at cycle 40; axior high at cycle 41.
- Back-to-back 0x00 then 0xFF with axiiv held high -> second start bit begins exactly 1 cycle after the first tx_done. Frames decode to 0x00 and 0xFF; two tx_done pulses total.
- axiiv pulsed with 0x3C mid-frame while sending 0x81 -> 0x3C ignored; only 0x81 appears on axiod; axior stays 0 until IDLE.
- rst asserted during data bit 3 of 0x55 -> axiod=1 at the next edge, no tx_done, axior=1 after release. A new 0x12 then transmits correctly.
- With UART_TX_PARITY_EN, STOP_BITS=2:
  - Send 0xA5 -> parity bit 0; 48-cycle frame.
  - Send 0x01 -> parity bit 1; stop period 8 cycles high.
